// File: rtl/elementary_pkg.sv
// Shared definitions for the elementary gate library.
// Select encodings used by the demultiplexers: the value of S that routes
// A to each output.
package elementary_pkg;

    localparam logic [1:0] SEL_Y0 = 2'b00;
    localparam logic [1:0] SEL_Y1 = 2'b01;
    localparam logic [1:0] SEL_Y2 = 2'b10;
    localparam logic [1:0] SEL_Y3 = 2'b11;

endpackage

// File: rtl/dmux4way_if.sv
// Bundle of the dmux4way data-path signals.
//   s      : 2-bit select
//   a      : data to be routed
//   y0..y3 : routed outputs (only the selected one carries a)
// master drives s/a and observes the outputs; slave is the demux side.
interface dmux4way_if #(
    parameter int WIDTH = 1
);
    logic [1:0]       s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;

    modport master (
        output s, a,
        input  y0, y1, y2, y3
    );

    modport slave (
        input  s, a,
        output y0, y1, y2, y3
    );
endinterface

// File: rtl/dmux2way.sv
// 1-to-2 demultiplexer, purely combinational.
//   Y0 : A when S selects the lower output, else 0
//   Y1 : A when S selects the upper output, else 0
//   S  : 1-bit select
//   A  : WIDTH-bit data, routed whole
module dmux2way
    import elementary_pkg::*;
#(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    input  logic             S,
    input  logic [WIDTH-1:0] A
);

    // Within a pair the low select bit decides; the encodings of Y0/Y1
    // differ only in bit 0.
    localparam logic SEL_LOW  = SEL_Y0[0];
    localparam logic SEL_HIGH = SEL_Y1[0];

    assign Y0 = (S == SEL_LOW)  ? A : '0;
    assign Y1 = (S == SEL_HIGH) ? A : '0;

endmodule

// File: rtl/dmux4way.sv
// 1-to-4 demultiplexer built from three dmux2way stages, with an optional
// output register.
//   Y0..Y3 : A on the output selected by S, 0 on the others
//   S      : 2-bit select (S[1] picks the pair, S[0] the output within it)
//   A      : WIDTH-bit data, routed whole
//   CLK    : rising-edge clock (unused when REG_OUT = 0)
//   RST    : asynchronous active-high reset (unused when REG_OUT = 0)
// REG_OUT = 1 gives one cycle of latency; REG_OUT = 0 is combinational.
module dmux4way
    import elementary_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic             CLK,
    input  logic             RST
);

    logic [WIDTH-1:0] pair_lo;
    logic [WIDTH-1:0] pair_hi;
    logic [WIDTH-1:0] dec_y0;
    logic [WIDTH-1:0] dec_y1;
    logic [WIDTH-1:0] dec_y2;
    logic [WIDTH-1:0] dec_y3;

    dmux2way #(.WIDTH(WIDTH)) u_pair (
        .Y0 (pair_lo),
        .Y1 (pair_hi),
        .S  (S[1]),
        .A  (A)
    );

    dmux2way #(.WIDTH(WIDTH)) u_lo (
        .Y0 (dec_y0),
        .Y1 (dec_y1),
        .S  (S[0]),
        .A  (pair_lo)
    );

    dmux2way #(.WIDTH(WIDTH)) u_hi (
        .Y0 (dec_y2),
        .Y1 (dec_y3),
        .S  (S[0]),
        .A  (pair_hi)
    );

    generate
        if (REG_OUT) begin : g_reg
            // All four outputs load together from one decode, so an output
            // can never pair an old select with new data.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    Y0 <= '0;
                    Y1 <= '0;
                    Y2 <= '0;
                    Y3 <= '0;
                end else begin
                    Y0 <= dec_y0;
                    Y1 <= dec_y1;
                    Y2 <= dec_y2;
                    Y3 <= dec_y3;
                end
            end
        end else begin : g_comb
            assign Y0 = dec_y0;
            assign Y1 = dec_y1;
            assign Y2 = dec_y2;
            assign Y3 = dec_y3;
        end
    endgenerate

endmodule

// File: tb/tb_dmux4way.sv
module tb_dmux4way;

    logic clk = 1'b0;
    logic rst;
    logic rst_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmux4way_if #(.WIDTH(1)) bus1 ();
    dmux4way_if #(.WIDTH(1)) busc ();
    dmux4way_if #(.WIDTH(8)) bus8 ();

    dmux4way #(.WIDTH(1), .REG_OUT(1'b1)) u_reg1 (
        .Y0(bus1.y0), .Y1(bus1.y1), .Y2(bus1.y2), .Y3(bus1.y3),
        .S(bus1.s), .A(bus1.a), .CLK(clk), .RST(rst)
    );

    dmux4way #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
        .Y0(busc.y0), .Y1(busc.y1), .Y2(busc.y2), .Y3(busc.y3),
        .S(busc.s), .A(busc.a), .CLK(clk), .RST(rst_c)
    );

    dmux4way #(.WIDTH(8), .REG_OUT(1'b1)) u_reg8 (
        .Y0(bus8.y0), .Y1(bus8.y1), .Y2(bus8.y2), .Y3(bus8.y3),
        .S(bus8.s), .A(bus8.a), .CLK(clk), .RST(rst)
    );

    // outputs packed as Y0,Y1,Y2,Y3 (MSB = Y0) for the 1-bit instances
    logic [3:0] y1_vec;
    logic [3:0] yc_vec;
    logic [7:0] y8 [4];
    assign y1_vec = {bus1.y0, bus1.y1, bus1.y2, bus1.y3};
    assign yc_vec = {busc.y0, busc.y1, busc.y2, busc.y3};
    assign y8[0]  = bus8.y0;
    assign y8[1]  = bus8.y1;
    assign y8[2]  = bus8.y2;
    assign y8[3]  = bus8.y3;

    // Reference: output k carries a when s == k, all others zero.
    function automatic logic [3:0] ref_vec1(input int s, input logic a);
        logic [3:0] v;
        v = 4'b0000;
        v[3 - s] = a;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        rst_c = 1'b0;
        bus1.s = 2'd0; bus1.a = 1'b1;
        bus8.s = 2'd0; bus8.a = 8'hFF;
        busc.s = 2'd0; busc.a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (y1_vec !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: got %b, want 0000", y1_vec);
        end
        @(posedge clk); #1;
        n_tests++;
        if (y1_vec !== 4'b0000 || y8[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got %b / %h, want 0000 / 00", y1_vec, y8[0]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_data();
        bus1.a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus1.s = 2'(k);
            @(posedge clk); #1;
            n_tests++;
            if (y1_vec !== 4'b0000) begin
                n_fail++;
                $display("FAIL zero_data s=%0d: got %b, want 0000", k, y1_vec);
            end
        end
    endtask

    task automatic test_onehot();
        logic [3:0] want;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus1.a = 1'b1;
            bus1.s = 2'(k);
            want = ref_vec1(k, 1'b1);
            @(posedge clk); #1;
            n_tests++;
            if (y1_vec !== want) begin
                n_fail++;
                $display("FAIL onehot s=%0d: got %b, want %b", k, y1_vec, want);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus1.a = 1'b1;
        bus1.s = 2'b10;
        @(posedge clk); #1;
        n_tests++;
        if (y1_vec !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got %b, want 0010", y1_vec);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (y1_vec !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_drop: got %b, want 0000", y1_vec);
        end
        @(posedge clk); #1;
        n_tests++;
        if (y1_vec !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_hold: got %b, want 0000", y1_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (y1_vec !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_release: got %b, want 0000", y1_vec);
        end
        @(posedge clk); #1;
        n_tests++;
        if (y1_vec !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_reset_resume: got %b, want 0010", y1_vec);
        end
    endtask

    task automatic test_comb();
        logic [3:0] want;
        busc.a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            busc.s = 2'(k);
            rst_c = ~rst_c;
            want = ref_vec1(k, 1'b1);
            #1;
            n_tests++;
            if (yc_vec !== want) begin
                n_fail++;
                $display("FAIL comb s=%0d: got %b, want %b", k, yc_vec, want);
            end
        end
        busc.a = 1'b0;
        #1;
        n_tests++;
        if (yc_vec !== 4'b0000) begin
            n_fail++;
            $display("FAIL comb_zero: got %b, want 0000", yc_vec);
        end
        rst_c = 1'b0;
    endtask

    task automatic test_wide();
        @(negedge clk);
        bus8.a = 8'hA5;
        bus8.s = 2'b11;
        @(posedge clk); #1;
        n_tests++;
        if (y8[3] !== 8'hA5 || y8[0] !== 8'h00 || y8[1] !== 8'h00 || y8[2] !== 8'h00) begin
            n_fail++;
            $display("FAIL wide_a5: got %h %h %h %h, want 00 00 00 a5", y8[0], y8[1], y8[2], y8[3]);
        end
        @(negedge clk);
        bus8.a = 8'h3C;
        bus8.s = 2'b00;
        #1;
        n_tests++;
        if (y8[3] !== 8'hA5 || y8[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL wide_hold: got %h %h %h %h, want 00 00 00 a5", y8[0], y8[1], y8[2], y8[3]);
        end
        @(posedge clk); #1;
        n_tests++;
        if (y8[0] !== 8'h3C || y8[1] !== 8'h00 || y8[2] !== 8'h00 || y8[3] !== 8'h00) begin
            n_fail++;
            $display("FAIL wide_3c: got %h %h %h %h, want 3c 00 00 00", y8[0], y8[1], y8[2], y8[3]);
        end
    endtask

    task automatic test_random();
        int         s_q [$];
        logic [7:0] a_q [$];
        int         s_exp;
        logic [7:0] a_exp;
        logic [7:0] want;
        int         nz;
        bit         bad;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            bus8.s = 2'($urandom_range(0, 3));
            bus8.a = 8'($urandom);
            s_q.push_back(int'(bus8.s));
            a_q.push_back(bus8.a);
            @(posedge clk); #1;
            s_exp = s_q.pop_front();
            a_exp = a_q.pop_front();
            bad = 1'b0;
            nz = 0;
            for (int k = 0; k < 4; k++) begin
                want = (k == s_exp) ? a_exp : 8'h00;
                if (y8[k] !== want) bad = 1'b1;
                if (y8[k] !== 8'h00) nz++;
            end
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL random cyc=%0d s=%0d a=%h: got %h %h %h %h", cyc, s_exp, a_exp,
                         y8[0], y8[1], y8[2], y8[3]);
            end
            n_tests++;
            if (nz > 1) begin
                n_fail++;
                $display("FAIL random_onehot cyc=%0d: got %0d nonzero outputs, want <= 1", cyc, nz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_data();
        test_onehot();
        test_async_reset();
        test_comb();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
